// File: rtl/alu_issue_ctrl.sv
// Issue controller between a command FIFO and an external combinational ALU.
// It accepts tagged commands, issues them in order, captures results and returns tagged responses.
`timescale 1ns/1ps
module alu_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_a,
    input  logic [31:0]       cmd_b,
    input  logic [3:0]        cmd_opcode,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [3:0]        alu_opcode,
    input  logic [31:0]       alu_result,
    input  logic              alu_zero,
    input  logic              alu_sign,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,
    output logic [TAG_W-1:0]  rsp_tag,
    input  logic              sticky_clr,
    output logic              sticky_carry,
    output logic              sticky_ovf,
    output logic [15:0]       op_count
);

    // state  | meaning
    // IDLE   | no command in flight, waiting for the FIFO to fill
    // ISSUE  | operands on alu_*, result captured at the end of this cycle
    // RESP   | response presented, waiting for rsp_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int PTR_W = $clog2(DEPTH);

    state_t state, state_nxt;

    logic [31:0]      fifo_a   [DEPTH];
    logic [31:0]      fifo_b   [DEPTH];
    logic [3:0]       fifo_op  [DEPTH];
    logic [TAG_W-1:0] fifo_tag [DEPTH];

    logic [PTR_W:0] wr_ptr, rd_ptr;
    logic           fifo_full, fifo_empty;
    logic           push, pop;
    logic           load_alu, load_err, capture;
    logic           head_legal;
    logic [31:0]    head_a, head_b;
    logic [3:0]     head_op;
    logic [TAG_W-1:0] head_tag;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;

    assign head_a     = fifo_a[rd_ptr[PTR_W-1:0]];
    assign head_b     = fifo_b[rd_ptr[PTR_W-1:0]];
    assign head_op    = fifo_op[rd_ptr[PTR_W-1:0]];
    assign head_tag   = fifo_tag[rd_ptr[PTR_W-1:0]];
    assign head_legal = (head_op <= 4'd8);

    assign rsp_valid  = (state == RESP);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_alu  = 1'b0;
        load_err  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_legal) begin
                        load_alu  = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        load_err  = 1'b1;
                        state_nxt = RESP;
                    end
                end
            end
            ISSUE: begin
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        if (head_legal) begin
                            load_alu  = 1'b1;
                            state_nxt = ISSUE;
                        end else begin
                            load_err  = 1'b1;
                            state_nxt = RESP;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr[PTR_W-1:0]]   <= cmd_a;
            fifo_b[wr_ptr[PTR_W-1:0]]   <= cmd_b;
            fifo_op[wr_ptr[PTR_W-1:0]]  <= cmd_opcode;
            fifo_tag[wr_ptr[PTR_W-1:0]] <= cmd_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_opcode   <= '0;
            rsp_result   <= '0;
            rsp_flags    <= '0;
            rsp_err      <= 1'b0;
            rsp_tag      <= '0;
            sticky_carry <= 1'b0;
            sticky_ovf   <= 1'b0;
            op_count     <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            if (pop)  rsp_tag <= head_tag;
            if (load_alu) begin
                alu_a      <= head_a;
                alu_b      <= head_b;
                alu_opcode <= head_op;
            end
            if (load_err) begin
                rsp_result <= '0;
                rsp_flags  <= '0;
                rsp_err    <= 1'b1;
            end
            if (capture) begin
                rsp_result <= alu_result;
                rsp_flags  <= {alu_zero, alu_sign, alu_carry, alu_overflow};
                rsp_err    <= 1'b0;
            end
            // A flag captured on the same edge as a clear still sets the bit.
            if (capture) begin
                sticky_carry <= (sticky_carry & ~sticky_clr) | alu_carry;
                sticky_ovf   <= (sticky_ovf & ~sticky_clr) | alu_overflow;
            end else if (sticky_clr) begin
                sticky_carry <= 1'b0;
                sticky_ovf   <= 1'b0;
            end
            if (rsp_valid && rsp_ready) op_count <= op_count + 16'd1;
        end
    end

endmodule
